// File: rtl/slow_set_ctl_if.sv
// Bus-side bundle for slow_set_ctl: decode/strobe inputs toward the controller,
// settings and slow-window state back out to the steering logic.
interface slow_set_ctl_if #(
   parameter int NDEV = 6,
   parameter int TW   = 4
);
   logic                   BACT;
   logic                   SetCSWR;
   logic [NDEV+TW+2:1]     A;
   logic [NDEV-1:0]        DevSel;
   logic                   TickEn;
   logic [NDEV-1:0]        SlowEn;
   logic [TW-1:0]          SlowTimeout;
   logic                   SlowClockGate;
   logic                   SetLocked;
   logic                   SlowActive;

   modport master (
      output BACT, SetCSWR, A, DevSel, TickEn,
      input  SlowEn, SlowTimeout, SlowClockGate, SetLocked, SlowActive
   );

   modport slave (
      input  BACT, SetCSWR, A, DevSel, TickEn,
      output SlowEn, SlowTimeout, SlowClockGate, SetLocked, SlowActive
   );
endinterface

// File: rtl/slow_set_ctl.sv
// Slow-device settings register (address-encoded writes, sticky lock) and
// the slow-window timer that the accelerator core reads as SlowActive.
module slow_set_ctl #(
   parameter int              NDEV     = 6,
   parameter int              TW       = 4,
   parameter logic [NDEV-1:0] SLOW_RST = 6'b111001,
   parameter logic [TW-1:0]   TO_RST   = 4'h3,
   parameter logic            CG_RST   = 1'b0
) (
   input  logic          CLK,
   input  logic          nPOR,
   slow_set_ctl_if.slave bus
);
   logic                   wr_r;
   logic [NDEV+TW+2:1]     a_r;
   logic                   bact_r;
   logic [NDEV-1:0]        en_r;
   logic [TW-1:0]          to_r;
   logic                   cg_r;
   logic                   lock_r;
   logic [TW-1:0]          cnt;
   logic [TW-1:0]          cnt_nx;
   logic                   active_r;
   logic                   qual;

   // Only the rising edge of BACT counts, so a held cycle loads once.
   assign qual = bus.BACT & ~bact_r & |(bus.DevSel & en_r);

   always_comb begin
      cnt_nx = cnt;
      if (qual)
         cnt_nx = to_r;
      else if (bus.TickEn && cnt != '0)
         cnt_nx = cnt - TW'(1);
   end

   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         wr_r     <= 1'b0;
         a_r      <= '0;
         bact_r   <= 1'b0;
         en_r     <= SLOW_RST;
         to_r     <= TO_RST;
         cg_r     <= CG_RST;
         lock_r   <= 1'b0;
         cnt      <= '0;
         active_r <= 1'b0;
      end else begin
         wr_r     <= bus.BACT & bus.SetCSWR;
         a_r      <= bus.A;
         bact_r   <= bus.BACT;
         cnt      <= cnt_nx;
         active_r <= (cnt_nx != '0);
         // The locking write still lands its own fields before closing the door.
         if (wr_r && !lock_r) begin
            cg_r   <= a_r[1];
            en_r   <= a_r[NDEV+1:2];
            to_r   <= a_r[NDEV+TW+1:NDEV+2];
            lock_r <= a_r[NDEV+TW+2];
         end
      end
   end

   assign bus.SlowEn        = en_r;
   assign bus.SlowTimeout   = to_r;
   assign bus.SlowClockGate = cg_r;
   assign bus.SetLocked     = lock_r;
   assign bus.SlowActive    = active_r;
endmodule
